// File: rtl/terminal_cell_engine.sv
// terminal_cell_engine: turns a decoded byte stream into character-cell writes
// on a ring-buffered text page in SDRAM. It handles the cursor, line wrap,
// hardware scroll, TAB, backspace and a run-length REPEAT command. It also
// reports the first-row and cursor-position updates on the video register port.
module terminal_cell_engine #(
  parameter int COLUMNS     = 80,
  parameter int ROWS        = 51,
  parameter int COL_W       = 7,
  parameter int ROW_W       = 6,
  parameter int ADDR_W      = 23,
  parameter int TAB_WIDTH   = 8,
  parameter int CLEAR_BURST = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready_n,
  input  logic [7:0]        unicode,
  input  logic              unicode_available,
  input  logic [23:0]       attr,
  output logic [ADDR_W-1:0] wr_address,
  output logic              wr_request,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_mask,
  output logic [8:0]        wr_burst_length,
  input  logic              wr_done,
  output logic [3:0]        register_index,
  output logic [22:0]       register_value
);

  localparam logic [3:0] VIDEO_NOP             = 4'd0;
  localparam logic [3:0] VIDEO_SET_FIRST_ROW   = 4'd1;
  localparam logic [3:0] VIDEO_CURSOR_POSITION = 4'd2;

  localparam int PAGE_CELLS  = ROWS * (2 ** COL_W);
  localparam int NUM_BURSTS  = (PAGE_CELLS + CLEAR_BURST - 1) / CLEAR_BURST;
  localparam int BURST_CNT_W = $clog2(NUM_BURSTS + 1);

  localparam logic [COL_W-1:0]       LAST_COL   = COL_W'(COLUMNS - 1);
  localparam logic [ROW_W-1:0]       LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]       ONE_X      = COL_W'(1);
  localparam logic [ROW_W-1:0]       ONE_Y      = ROW_W'(1);
  localparam logic [COL_W:0]         TAB_MASK   = (COL_W + 1)'(TAB_WIDTH - 1);
  localparam logic [COL_W:0]         TAB_LIMIT  = (COL_W + 1)'(COLUMNS - 1);
  localparam logic [BURST_CNT_W-1:0] LAST_BURST = BURST_CNT_W'(NUM_BURSTS - 1);
  localparam logic [BURST_CNT_W-1:0] ONE_BURST  = BURST_CNT_W'(1);
  localparam logic [ADDR_W-1:0]      CELL_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0]      BURST_STEP = ADDR_W'(CLEAR_BURST * 4);
  localparam logic [31:0]            BLANK_CELL = 32'h0000_0020;

  // BOOT is only the reset state; it exists so that reset itself shows an
  // idle register port and a busy ready_n before the page clear starts.
  typedef enum logic [3:0] {
    BOOT, IDLE, CELL_REQ, CELL_WAIT, REP_ARG, REP_REQ, REP_WAIT,
    SCROLL_SET, SCROLL_REQ, SCROLL_WAIT, PAGE_SET, PAGE_REQ, PAGE_WAIT
  } state_t;

  state_t state, state_n;

  logic [COL_W-1:0]       cur_x, cur_x_n;
  logic [ROW_W-1:0]       cur_y, cur_y_n;
  logic [ROW_W-1:0]       first_row, first_row_n;
  logic [7:0]             last_char, last_char_n;
  logic [23:0]            cell_attr, cell_attr_n;
  logic [7:0]             rep_count, rep_count_n;
  logic [COL_W-1:0]       clr_count, clr_count_n;
  logic [BURST_CNT_W-1:0] burst_count, burst_count_n;
  logic [ADDR_W-1:0]      wr_address_n;
  logic [31:0]            wr_data_n;
  logic [8:0]             wr_burst_length_n;
  logic                   ready_n_n;
  logic                   accept;

  logic [COL_W-1:0] adv_x;
  logic [ROW_W-1:0] adv_y;
  logic             adv_scroll;
  logic [ROW_W-1:0] scrolled_row;
  logic [COL_W:0]   tab_raw;
  logic [COL_W-1:0] tab_x;

  // Physical row is the logical row rotated by first_row, wrapping at ROWS.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COL_W-1:0] x,
                                                   input logic [ROW_W-1:0] y,
                                                   input logic [ROW_W-1:0] fr);
    logic [ROW_W:0]   sum;
    logic [ROW_W-1:0] phys;
    sum = {1'b0, y} + {1'b0, fr};
    if (sum >= (ROW_W + 1)'(ROWS)) sum = sum - (ROW_W + 1)'(ROWS);
    phys = sum[ROW_W-1:0];
    return ADDR_W'({phys, x, 2'b00});
  endfunction

  assign wr_mask = 4'hF;

  // Cursor arithmetic shared by every path: one-cell advance with wrap, the
  // first row after a scroll, and the next tab stop clamped to the last column.
  always_comb begin
    adv_x        = cur_x + ONE_X;
    adv_y        = cur_y;
    adv_scroll   = 1'b0;
    if (cur_x == LAST_COL) begin
      adv_x = '0;
      if (cur_y == LAST_ROW) adv_scroll = 1'b1;
      else                   adv_y      = cur_y + ONE_Y;
    end
    scrolled_row = (first_row == LAST_ROW) ? '0 : first_row + ONE_Y;
    tab_raw      = ({1'b0, cur_x} | TAB_MASK) + (COL_W + 1)'(1);
    tab_x        = (tab_raw > TAB_LIMIT) ? LAST_COL : tab_raw[COL_W-1:0];
  end

  // Next-state and datapath updates; a REPEAT that scrolls resumes after the clear.
  always_comb begin
    accept            = (state == IDLE || state == REP_ARG) && !ready_n && unicode_available;
    state_n           = state;
    cur_x_n           = cur_x;
    cur_y_n           = cur_y;
    first_row_n       = first_row;
    last_char_n       = last_char;
    cell_attr_n       = cell_attr;
    rep_count_n       = rep_count;
    clr_count_n       = clr_count;
    burst_count_n     = burst_count;
    wr_address_n      = wr_address;
    wr_data_n         = wr_data;
    wr_burst_length_n = wr_burst_length;

    case (state)
      BOOT: begin
        cur_x_n     = '0;
        cur_y_n     = '0;
        first_row_n = '0;
        state_n     = PAGE_SET;
      end
      IDLE: begin
        if (accept) begin
          rep_count_n = '0;
          if (unicode >= 8'h20) begin
            last_char_n  = unicode;
            cell_attr_n  = attr;
            wr_address_n = cell_addr(cur_x, cur_y, first_row);
            wr_data_n    = {attr, unicode};
            state_n      = CELL_REQ;
          end else begin
            case (unicode)
              8'h0D: cur_x_n = '0;
              8'h08: if (cur_x != '0) cur_x_n = cur_x - ONE_X;
              8'h09: cur_x_n = tab_x;
              8'h0A: begin
                if (cur_y == LAST_ROW) begin
                  first_row_n = scrolled_row;
                  state_n     = SCROLL_SET;
                end else begin
                  cur_y_n = cur_y + ONE_Y;
                end
              end
              8'h0C: begin
                cur_x_n     = '0;
                cur_y_n     = '0;
                first_row_n = '0;
                state_n     = PAGE_SET;
              end
              8'h12:   state_n = REP_ARG;
              default: state_n = IDLE;
            endcase
          end
        end
      end
      REP_ARG: begin
        if (accept) begin
          if (unicode == 8'h00) begin
            state_n = IDLE;
          end else begin
            rep_count_n  = unicode;
            wr_address_n = cell_addr(cur_x, cur_y, first_row);
            wr_data_n    = {cell_attr, last_char};
            state_n      = REP_REQ;
          end
        end
      end
      CELL_REQ: state_n = CELL_WAIT;
      CELL_WAIT: begin
        if (wr_done) begin
          cur_x_n = adv_x;
          cur_y_n = adv_y;
          if (adv_scroll) begin
            first_row_n = scrolled_row;
            state_n     = SCROLL_SET;
          end else begin
            state_n = IDLE;
          end
        end
      end
      REP_REQ: state_n = REP_WAIT;
      REP_WAIT: begin
        if (wr_done) begin
          rep_count_n = rep_count - 8'd1;
          cur_x_n     = adv_x;
          cur_y_n     = adv_y;
          if (adv_scroll) begin
            first_row_n = scrolled_row;
            state_n     = SCROLL_SET;
          end else if (rep_count != 8'd1) begin
            wr_address_n = cell_addr(adv_x, adv_y, first_row);
            wr_data_n    = {cell_attr, last_char};
            state_n      = REP_REQ;
          end else begin
            state_n = IDLE;
          end
        end
      end
      SCROLL_SET: begin
        clr_count_n  = '0;
        wr_address_n = cell_addr('0, LAST_ROW, first_row);
        wr_data_n    = BLANK_CELL;
        state_n      = SCROLL_REQ;
      end
      SCROLL_REQ: state_n = SCROLL_WAIT;
      SCROLL_WAIT: begin
        if (wr_done) begin
          if (clr_count == LAST_COL) begin
            if (rep_count != 8'd0) begin
              wr_address_n = cell_addr(cur_x, cur_y, first_row);
              wr_data_n    = {cell_attr, last_char};
              state_n      = REP_REQ;
            end else begin
              state_n = IDLE;
            end
          end else begin
            clr_count_n  = clr_count + ONE_X;
            wr_address_n = wr_address + CELL_STEP;
            state_n      = SCROLL_REQ;
          end
        end
      end
      PAGE_SET: begin
        burst_count_n     = '0;
        wr_address_n      = '0;
        wr_data_n         = BLANK_CELL;
        wr_burst_length_n = 9'(CLEAR_BURST);
        state_n           = PAGE_REQ;
      end
      PAGE_REQ: state_n = PAGE_WAIT;
      PAGE_WAIT: begin
        if (wr_done) begin
          if (burst_count == LAST_BURST) begin
            wr_burst_length_n = 9'd1;
            state_n           = IDLE;
          end else begin
            burst_count_n = burst_count + ONE_BURST;
            wr_address_n  = wr_address + BURST_STEP;
            state_n       = PAGE_REQ;
          end
        end
      end
      default: state_n = BOOT;
    endcase

    ready_n_n = accept || !(state_n == IDLE || state_n == REP_ARG);
  end

  // Write strobe and video register port are decoded from the current state.
  always_comb begin
    wr_request     = 1'b0;
    register_index = VIDEO_NOP;
    register_value = '0;
    case (state)
      CELL_REQ, REP_REQ, SCROLL_REQ, PAGE_REQ: wr_request = 1'b1;
      IDLE: begin
        register_index = VIDEO_CURSOR_POSITION;
        register_value = 23'({cur_y, cur_x});
      end
      SCROLL_SET: begin
        register_index = VIDEO_SET_FIRST_ROW;
        register_value = 23'({first_row, {(COL_W + 2){1'b0}}});
      end
      PAGE_SET: register_index = VIDEO_SET_FIRST_ROW;
      default: ;
    endcase
  end

  // State and datapath registers; reset aborts any write in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= BOOT;
      cur_x           <= '0;
      cur_y           <= '0;
      first_row       <= '0;
      last_char       <= 8'h20;
      cell_attr       <= '0;
      rep_count       <= '0;
      clr_count       <= '0;
      burst_count     <= '0;
      wr_address      <= '0;
      wr_data         <= '0;
      wr_burst_length <= 9'd1;
      ready_n         <= 1'b1;
    end else begin
      state           <= state_n;
      cur_x           <= cur_x_n;
      cur_y           <= cur_y_n;
      first_row       <= first_row_n;
      last_char       <= last_char_n;
      cell_attr       <= cell_attr_n;
      rep_count       <= rep_count_n;
      clr_count       <= clr_count_n;
      burst_count     <= burst_count_n;
      wr_address      <= wr_address_n;
      wr_data         <= wr_data_n;
      wr_burst_length <= wr_burst_length_n;
      ready_n         <= ready_n_n;
    end
  end

endmodule
